// File: rtl/handle_allocator.sv
// Handle-table initiator: turns alloc/free requests into command-space bus op sequences
// (reserve free id, program map base, set/clear valid) and reports the resulting handle id.
module handle_allocator #(
  parameter int unsigned W       = 16,
  parameter int unsigned HW      = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_kind,
  input  logic [W-HW-1:0] i_req_base,
  input  logic [HW-1:0] i_req_id,
  output logic          o_rsp_valid,
  output logic [1:0]    o_rsp_err,
  output logic [HW-1:0] o_rsp_id,
  output logic [2:0]    o_op,
  output logic [W-1:0]  o_address,
  output logic [W-1:0]  o_data,
  input  logic          i_bus_ack,
  input  logic [W-1:0]  i_bus_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpRead  = 3'd1;
  localparam logic [2:0] OpWrite = 3'd2;

  typedef enum logic [2:0] {
    StIdle, StGetId, StMap, StSetValid, StClrValid, StResp
  } state_e;

  state_e          state_q;
  logic [W-HW-1:0] base_q;
  logic [HW-1:0]   id_q;
  logic [CW-1:0]   cnt_q;
  logic            timeout;
  logic            unused_rdata;

  // Only the id field of the free-id read is meaningful.
  assign unused_rdata = ^i_bus_rdata[W-1:HW];
  assign timeout      = (cnt_q == CW'(TIMEOUT - 1)) && !i_bus_ack;

  // Command address: {1, all-ones handle, cmd, zeros, id}.
  function automatic logic [W-1:0] cmd_addr(input logic [1:0] cmd, input logic [HW-1:0] id);
    logic [W-1:0] a;
    a              = '0;
    a[W-1]         = 1'b1;
    a[W-2 -: HW]   = '1;
    a[W-2-HW -: 2] = cmd;
    a[HW-1:0]      = id;
    return a;
  endfunction

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= '0;
      o_rsp_id    <= '0;
      o_op        <= OpNop;
      o_address   <= '0;
      o_data      <= '0;
      base_q      <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            base_q      <= i_req_base;
            id_q        <= i_req_id;
            cnt_q       <= '0;
            if (!i_req_kind) begin
              state_q   <= StGetId;
              o_op      <= OpRead;
              o_address <= cmd_addr(2'd0, '0);
              o_data    <= '0;
            end else if (i_req_id == '1) begin
              state_q     <= StResp;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 2'd2;
            end else begin
              state_q   <= StClrValid;
              o_op      <= OpWrite;
              o_address <= cmd_addr(2'd2, i_req_id);
              o_data    <= '0;
            end
          end
        end
        StResp: begin
          state_q     <= StIdle;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= '0;
          o_rsp_id    <= '0;
        end
        default: begin
          // Bus states: hold the op until ack, bail out with err 3 on timeout.
          if (i_bus_ack || timeout) begin
            o_op      <= OpNop;
            o_address <= '0;
            o_data    <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (timeout) begin
            state_q     <= StResp;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 2'd3;
          end else if (i_bus_ack) begin
            unique case (state_q)
              StGetId: begin
                if (i_bus_rdata[HW-1:0] == '1) begin
                  state_q     <= StResp;
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= 2'd1;
                end else begin
                  state_q   <= StMap;
                  id_q      <= i_bus_rdata[HW-1:0];
                  o_op      <= OpWrite;
                  o_address <= cmd_addr(2'd1, i_bus_rdata[HW-1:0]);
                  o_data    <= {{HW{1'b0}}, base_q};
                end
              end
              StMap: begin
                state_q   <= StSetValid;
                o_op      <= OpWrite;
                o_address <= cmd_addr(2'd2, id_q);
                o_data    <= {{(W-1){1'b0}}, 1'b1};
              end
              default: begin
                state_q     <= StResp;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 2'd0;
                o_rsp_id    <= id_q;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handle_allocator.sv
// Self-checking bench for handle_allocator: vector table plus bus/response scoreboards.
module tb_handle_allocator;

  localparam int W = 16;
  localparam int HW = 3;
  localparam int TIMEOUT = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid, req_ready, req_kind;
  logic [12:0]   req_base;
  logic [2:0]    req_id;
  logic          rsp_valid;
  logic [1:0]    rsp_err;
  logic [2:0]    rsp_id;
  logic [2:0]    op;
  logic [15:0]   address, data;
  logic          bus_ack;
  logic [15:0]   bus_rdata;

  always #5 clock = ~clock;

  handle_allocator #(.W(W), .HW(HW), .TIMEOUT(TIMEOUT)) dut (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_kind (req_kind),
    .i_req_base (req_base),
    .i_req_id   (req_id),
    .o_rsp_valid(rsp_valid),
    .o_rsp_err  (rsp_err),
    .o_rsp_id   (rsp_id),
    .o_op       (op),
    .o_address  (address),
    .o_data     (data),
    .i_bus_ack  (bus_ack),
    .i_bus_rdata(bus_rdata)
  );

  typedef struct { logic [2:0] op; logic [15:0] addr; logic [15:0] data; } bus_t;
  typedef struct { logic [1:0] err; logic [2:0] id; int lat; int acc; } rsp_t;
  typedef struct {
    bit kind; logic [12:0] base; logic [2:0] id; logic [15:0] rdata; int delay; bit ack_en;
    logic [1:0] err; logic [2:0] rid; int lat;
  } vec_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   errors = 0;
  int   checks = 0;
  int   n = 0;
  int   ack_delay = 0;
  bit   ack_en = 1'b1;
  bit   idle_ack = 1'b0;
  logic [15:0] rd_val = '0;
  vec_t vecs[11];

  always @(posedge clock) n <= n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ca(input int cmd, input logic [2:0] id);
    return 16'hF000 | (16'(cmd) << 10) | {13'd0, id};
  endfunction

  // Bus target: checks each new op against the scoreboard and its stability while waiting.
  initial begin : slave
    bit   in_op;
    int   waited;
    bus_t e;
    in_op = 1'b0; waited = 0; bus_ack = 1'b0; bus_rdata = '0;
    e = '{3'd0, 16'd0, 16'd0};
    forever begin
      @(negedge clock);
      bus_ack = 1'b0;
      bus_rdata = '0;
      if (reset_n && op != 3'd0) begin
        if (!in_op) begin
          in_op = 1'b1;
          waited = 0;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_op: got op=%0d addr=0x%h data=0x%h expected none",
                     op, address, data);
          end else begin
            e = exp_bus.pop_front();
            check("bus_op", op, e.op);
            check("bus_addr", address, e.addr);
            check("bus_data", data, e.data);
          end
        end else begin
          check("hold_op", op, e.op);
          check("hold_addr", address, e.addr);
          check("hold_data", data, e.data);
        end
        if (ack_en && waited == ack_delay) begin
          bus_ack = 1'b1;
          bus_rdata = rd_val;
          in_op = 1'b0;
        end else begin
          waited++;
        end
      end else begin
        in_op = 1'b0;
        if (idle_ack) begin
          bus_ack = 1'b1;
          bus_rdata = 16'h0003;
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        check("rsp_single_pulse", {31'd0, prev}, 32'd0);
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got err=%0d id=%0d expected none", rsp_err, rsp_id);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_err", rsp_err, e.err);
          check("rsp_id", rsp_id, e.id);
          check("rsp_latency", n - e.acc, e.lat);
        end
      end
      prev = rsp_valid;
    end
  end

  task automatic run_vec(input vec_t v);
    rsp_t r;
    @(negedge clock);
    ack_delay = v.delay; ack_en = v.ack_en; rd_val = v.rdata;
    if (!v.kind) begin
      exp_bus.push_back('{3'd1, ca(0, 3'd0), 16'd0});
      if (v.ack_en && v.rdata[2:0] != 3'b111) begin
        exp_bus.push_back('{3'd2, ca(1, v.rdata[2:0]), {3'd0, v.base}});
        exp_bus.push_back('{3'd2, ca(2, v.rdata[2:0]), 16'd1});
      end
    end else if (v.id != 3'b111) begin
      exp_bus.push_back('{3'd2, ca(2, v.id), 16'd0});
    end
    req_valid = 1'b1; req_kind = v.kind; req_base = v.base; req_id = v.id;
    for (int t = 0; t < 50 && !req_ready; t++) @(negedge clock);
    check("req_ready", {31'd0, req_ready}, 32'd1);
    r.err = v.err; r.id = v.rid; r.lat = v.lat; r.acc = n;
    exp_rsp.push_back(r);
    @(negedge clock);
    req_valid = 1'b0; req_kind = 1'b0; req_base = '0; req_id = '0;
    for (int t = 0; t < 300 && exp_rsp.size() != 0; t++) @(negedge clock);
    check("rsp_seen", exp_rsp.size(), 0);
    check("bus_drained", exp_bus.size(), 0);
    exp_rsp.delete();
    exp_bus.delete();
  endtask

  initial begin : main
    req_valid = 1'b0; req_kind = 1'b0; req_base = '0; req_id = '0;
    //        kind  base      id    rdata     dly ack  err   rid   lat
    vecs[0]  = '{1'b0, 13'h0005, 3'd0, 16'h0002, 0, 1'b1, 2'd0, 3'd2, 4};
    vecs[1]  = '{1'b0, 13'h1ABC, 3'd0, 16'h0007, 0, 1'b1, 2'd1, 3'd0, 2};
    vecs[2]  = '{1'b1, 13'h0000, 3'd3, 16'h0000, 0, 1'b1, 2'd0, 3'd3, 2};
    vecs[3]  = '{1'b1, 13'h0000, 3'd7, 16'h0000, 0, 1'b1, 2'd2, 3'd0, 1};
    vecs[4]  = '{1'b0, 13'h0123, 3'd0, 16'h0005, 5, 1'b1, 2'd0, 3'd5, 19};
    vecs[5]  = '{1'b0, 13'h0042, 3'd0, 16'h0000, 0, 1'b0, 2'd3, 3'd0, 65};
    vecs[6]  = '{1'b0, 13'h1FFF, 3'd0, 16'hFFF8, 0, 1'b1, 2'd0, 3'd0, 4};
    vecs[7]  = '{1'b1, 13'h0000, 3'd0, 16'h0000, 2, 1'b1, 2'd0, 3'd0, 4};
    vecs[8]  = '{1'b1, 13'h0000, 3'd6, 16'h0000, 0, 1'b0, 2'd3, 3'd0, 65};
    vecs[9]  = '{1'b0, 13'h0000, 3'd0, 16'h0006, 1, 1'b1, 2'd0, 3'd6, 7};
    vecs[10] = '{1'b0, 13'h0777, 3'd0, 16'h00FF, 2, 1'b1, 2'd1, 3'd0, 4};

    repeat (3) @(negedge clock);
    check("rst_op", op, 0);
    check("rst_address", address, 0);
    check("rst_data", data, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_ready", {31'd0, req_ready}, 1);
    reset_n = 1'b1;

    // Acks while idle must not start anything.
    @(negedge clock);
    idle_ack = 1'b1;
    repeat (4) @(negedge clock);
    idle_ack = 1'b0;
    @(negedge clock);
    check("idle_ack_op", op, 0);
    check("idle_ack_ready", {31'd0, req_ready}, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during MAP: sequence aborts with no response.
    @(negedge clock);
    ack_delay = 3; ack_en = 1'b1; rd_val = 16'h0004;
    exp_bus.push_back('{3'd1, ca(0, 3'd0), 16'd0});
    exp_bus.push_back('{3'd2, ca(1, 3'd4), 16'h00AA});
    req_valid = 1'b1; req_kind = 1'b0; req_base = 13'h00AA; req_id = '0;
    check("mid_rst_accept_ready", {31'd0, req_ready}, 1);
    @(negedge clock);
    req_valid = 1'b0;
    for (int t = 0; t < 50 && op != 3'd2; t++) @(negedge clock);
    check("mid_rst_map_reached", op, 2);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_op", op, 0);
    check("mid_rst_address", address, 0);
    check("mid_rst_ready", {31'd0, req_ready}, 1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    @(negedge clock);
    check("mid_rst_ops_seen", exp_bus.size(), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_op", op, 0);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
